frame_monitor: RTL



---
 rtl/frame_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/frame_monitor.sv
// Frame monitor: delimits rx_dv runs into frames, checks length and additive checksum,
// queues one descriptor per frame and exposes counters/status/descriptors on the simple bus.
module frame_monitor #(
  parameter int DEPTH   = 8,
  parameter int MIN_LEN = 4,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        bus_cmd_valid,
  input  logic        bus_op,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wr_data,
  output logic [15:0] bus_rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [11:0] LEN_MIN = 12'(MIN_LEN);
  localparam logic [11:0] LEN_MAX = 12'(MAX_LEN);
  localparam logic [11:0] LEN_SAT = 12'(MAX_LEN + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, IGNORE} state_t;

  state_t      state, state_nxt;
  logic [11:0] len, len_nxt;
  logic [7:0]  sum, sum_nxt;
  logic        frame_end;
  logic        enable;
  logic [15:0] good_cnt, err_cnt, drop_cnt;
  logic [15:0] mem [DEPTH];
  logic [AW:0] wp, rp, level;
  logic        empty, full, rd, wr, clear, pop, push, drop;
  logic [2:0]  err;
  logic [15:0] desc, rd_mux;
  logic [4:0]  lvl5;
  logic        unused_wr_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      sum   <= sum_nxt;
    end
  end

  // Enable is only consulted when a frame starts, so toggling it mid-frame is harmless.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    sum_nxt   = sum;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (rx_dv) begin
          if (enable) begin
            state_nxt = RECV;
            len_nxt   = 12'd1;
            sum_nxt   = rxd;
          end else begin
            state_nxt = IGNORE;
          end
        end
      end
      RECV: begin
        if (rx_dv) begin
          len_nxt = (len >= LEN_SAT) ? LEN_SAT : len + 12'd1;
          sum_nxt = sum + rxd;
        end else begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      IGNORE: begin
        if (!rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign err  = {len > LEN_MAX, len < LEN_MIN, sum != 8'h00};
  assign desc = {err, 1'b0, len};

  assign wr    = bus_cmd_valid & bus_op;
  assign rd    = bus_cmd_valid & ~bus_op;
  assign clear = wr && (bus_addr == 16'h0010) && bus_wr_data[1];
  assign level = wp - rp;
  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign pop   = rd && (bus_addr == 16'h0014) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push  = frame_end && (!full || pop);
  assign drop  = frame_end && full && !pop;
  assign lvl5  = 5'(level);
  assign unused_wr_bits = ^bus_wr_data[15:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= desc;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b1;
      good_cnt <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr && (bus_addr == 16'h0010)) enable <= bus_wr_data[0];
      if (clear) begin
        good_cnt <= '0;
        err_cnt  <= '0;
        drop_cnt <= '0;
      end else begin
        if (frame_end && (err == 3'b000)) good_cnt <= sat_inc(good_cnt);
        if (frame_end && (err != 3'b000)) err_cnt  <= sat_inc(err_cnt);
        if (drop) drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      16'h0010: rd_mux = {15'd0, enable};
      16'h0011: rd_mux = good_cnt;
      16'h0012: rd_mux = err_cnt;
      16'h0013: rd_mux = {7'd0, lvl5, 2'b00, full, empty};
      16'h0014: rd_mux = empty ? 16'h0000 : mem[rp[AW-1:0]];
      16'h0015: rd_mux = drop_cnt;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_rd_data <= '0;
    else if (rd) bus_rd_data <= rd_mux;
  end

endmodule
